// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared types, opcode constants and helpers for the op sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  localparam logic [3:0] OP_X1 = 4'b0001;
  localparam logic [3:0] OP_X2 = 4'b0010;
  localparam logic [3:0] OP_X3 = 4'b0011;
  localparam logic [3:0] OP_X4 = 4'b0100;
  localparam logic [3:0] OP_X5 = 4'b0101;
  localparam logic [3:0] OP_X6 = 4'b0110;
  localparam logic [3:0] OP_X7 = 4'b0111;
  localparam logic [3:0] OP_X8 = 4'b0000;

  localparam logic [7:0] DEF_MULTI_MASK = 8'b0110_0000;
  localparam int         DEF_MULTI_LAT  = 4;

  // Only the lower eight codes select a mux leg; anything with the top bit set is unmapped.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/result handshake and mux bundle for the op sequencer
interface alu_op_sequencer_if #(
  parameter int N = 32
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_opcode;
  logic [3:0]   mux_sel;
  logic         unit_start;
  logic [N-1:0] mux_out;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic         out_err;
  logic         busy;

  modport master (
    output flush, in_valid, in_opcode, mux_out, out_ready,
    input  in_ready, mux_sel, unit_start, out_valid, out_result, out_err, busy
  );

  modport slave (
    input  flush, in_valid, in_opcode, mux_out, out_ready,
    output in_ready, mux_sel, unit_start, out_valid, out_result, out_err, busy
  );
endinterface

// File: rtl/alu_op_sequencer_lat_counter.sv
// rtl/alu_op_sequencer_lat_counter.sv - loadable 4-bit latency down-counter with zero flag
module alu_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Clear beats load beats decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue controller for the execute-stage result mux
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         N          = 32,
  parameter logic [7:0] MULTI_MASK = DEF_MULTI_MASK,
  parameter int         MULTI_LAT  = DEF_MULTI_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);

  seq_state_e   state_q, state_d;
  logic [3:0]   mux_sel_q, mux_sel_d;
  logic         unit_start_q, unit_start_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic         out_err_q, out_err_d;

  logic         in_ready;
  logic         accept;
  logic         op_legal;
  logic         op_multi;
  logic [3:0]   op_lat_m1;
  logic         cnt_clr, cnt_load, cnt_en, cnt_zero;

  // A new op may issue from IDLE, or from HOLD on the same edge the held result retires.
  assign in_ready  = !bus.flush &&
                     ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign op_legal  = !is_illegal_op(bus.in_opcode);
  assign op_multi  = MULTI_MASK[bus.in_opcode[2:0]];
  assign op_lat_m1 = op_multi ? 4'(MULTI_LAT - 1) : 4'd0;

  alu_lat_counter u_lat_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (op_lat_m1),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  // Next-state and register updates; flush overrides every other transition.
  always_comb begin
    state_d      = state_q;
    mux_sel_d    = mux_sel_q;
    unit_start_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;

    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
      cnt_clr     = 1'b1;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_zero) begin
            out_result_d = bus.mux_out;
            out_err_d    = 1'b0;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        if (op_legal) begin
          mux_sel_d    = bus.in_opcode;
          state_d      = EXEC;
          cnt_load     = 1'b1;
          unit_start_d = op_multi;
          out_valid_d  = 1'b0;
        end else begin
          state_d      = HOLD;
          out_result_d = '0;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mux_sel_q    <= 4'b0000;
      unit_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mux_sel_q    <= mux_sel_d;
      unit_start_q <= unit_start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.unit_start = unit_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue controller for the 8-way functional-unit result mux in the execute stage.
- Accepts one opcode at a time over a valid/ready handshake and drives the registered mux select.
- Fires a start pulse to multi-cycle units, waits the unit's fixed latency, then captures the mux output.
- Presents the captured result downstream over a second valid/ready handshake.

Parameters:
- N, 32, datapath width of mux output and result.
- MULTI_MASK, 8'b0110_0000, bit i set means opcode {1'b0,i[2:0]} is multi-cycle.
- MULTI_LAT, 4, cycles from issue to capture for multi-cycle opcodes; legal range 1..15.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort, returns to IDLE.
- in_valid  in  1  opcode request valid.
- in_ready  out  1  sequencer can accept an opcode.
- in_opcode  in  4  requested opcode.
- mux_sel  out  4  registered select to the result mux.
- unit_start  out  1  one-cycle pulse at issue of a multi-cycle opcode.
- mux_out  in  N  result mux output.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  N  captured result.
- out_err  out  1  captured op was illegal; valid with out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values, all registered: state=IDLE, mux_sel=4'b0000, unit_start=0, out_valid=0, out_result=0, out_err=0, counter=0.
- Legal opcodes are 4'b0000..4'b0111. Any opcode with opcode[3]=1 is illegal.
- States: IDLE, EXEC, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Combinational, and 0 while flush=1.
- Accept happens at a rising edge where in_valid & in_ready.
- Legal accept:
  - mux_sel<=in_opcode and state<=EXEC.
  - counter<=L-1, where L=MULTI_LAT if MULTI_MASK[in_opcode[2:0]], else L=1.
  - unit_start<=1 for exactly one cycle if multi-cycle.
- Illegal accept:
  - state<=HOLD, out_result<=0, out_err<=1, out_valid<=1.
  - mux_sel unchanged, no unit_start.
- EXEC:
  - If counter!=0, decrement.
  - If counter==0, out_result<=mux_out, out_err<=0, out_valid<=1, state<=HOLD.
  - Capture edge is accept edge + L. mux_out values before the capture edge are ignored.
- HOLD:
  - out_valid=1, with out_result and out_err stable until out_ready.
  - On out_ready without accept: out_valid<=0, state<=IDLE.
  - On out_ready with an accept at the same edge: result retires and the new op issues at that edge, so no bubble. Single-cycle throughput is 1 op per 2 cycles.
- mux_sel holds the last issued opcode outside EXEC.
- flush has priority over everything except reset:
  - At the next edge: state<=IDLE, out_valid<=0, out_err<=0, unit_start<=0, counter<=0.
  - out_result and mux_sel hold their values.
  - An in_valid present in the same cycle is not accepted.
- rst_n low mid-EXEC or mid-HOLD forces reset values immediately, with no capture. In-flight unit work is discarded.
- MULTI_LAT=1 makes multi-cycle opcodes timing-identical to single-cycle ones, but unit_start still pulses.
- Counter width is 4 bits.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state enum (IDLE/EXEC/HOLD);
  - opcode constants OP_X1=4'b0001 .. OP_X7=4'b0111, OP_X8=4'b0000;
  - the illegal-opcode test as a function;
  - default MULTI_MASK/MULTI_LAT constants.
- One sub-module, alu_lat_counter: loadable 4-bit down-counter with load, enable and zero flag, instantiated once.
- FSM and handshake logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> immediately out_valid=0, in_ready=1, busy=0, mux_sel=0000, out_result=0.
- Single op: in_opcode=0011 accepted, mux_out=32'hDEADBEEF -> mux_sel=0011, out_valid one cycle after accept, out_result=DEADBEEF, out_err=0, unit_start never high.
- Multi op: in_opcode=0101, MULTI_LAT=4, mux_out=1111_1111 until accept+3 then 0000_00A5 -> unit_start one cycle, out_valid at accept+4, out_result=0000_00A5.
- Illegal: in_opcode=1010 -> out_valid next cycle, out_err=1, out_result=0, mux_sel unchanged, no unit_start.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles -> out_result stable and in_ready=0.
  - Then out_ready=1 with in_valid and opcode 0000 -> retire and accept on the same edge, mux_sel=0000, busy never drops.
- Abort:
  - flush at accept+2 of a MULTI_LAT=4 op -> IDLE next edge, out_valid never asserted, next op accepted normally.
  - Repeat the same point with rst_n pulse -> same outcome plus reset values.
